multi_debounce: RTL and testbench

- Parametrised N-channel switch debouncer; successor to the single-channel datapath/controlpath debouncer.
- Each channel filters one raw switch input. It produces a registered stable level, plus one-cycle rise and fall ticks.
- A counter step enable allows millisecond-scale debounce from a fast clock. A busy flag is provided per channel.
- Sits between board switch/button pins and control logic.

---
 rtl/multi_debounce.sv | 166 ++++++++++++++++
 tb/tb_multi_debounce.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// multi_debounce -- N-channel switch debouncer.
//
// Each channel runs an independent LOW/WAIT_HI/HIGH/WAIT_LO filter.
// A new level is accepted only after the sampled input holds it on
// DB_CYCLES+1 consecutive enabled edges, counting the edge that entered WAIT.
// Any reversion during WAIT drops the channel back to its stable state.
// State and counter advance only on edges where step_en=1.
// The one-cycle rise/fall ticks are registered every clk, so each tick is
// exactly one clk wide whatever the step_en duty cycle.
//
// Optional: define MULTI_DEBOUNCE_SYNC_EN to pass each sw bit through a
// 2-flop synchroniser. The synchroniser is clocked every clk, independent of
// step_en, and adds 2 clk of latency. Without the macro, sw must already be
// synchronous to clk.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   step_en  sample/step enable (tie to 1 for per-clock stepping)
//   sw       raw switch inputs, bit i = channel i
//   db_level debounced stable level
//   db_rise  one-clk pulse on accepted 0->1
//   db_fall  one-clk pulse on accepted 1->0
//   db_busy  channel is in a WAIT state

module multi_debounce_lane #(
  parameter int DB_CYCLES   = 10,
  parameter int CNT_W       = 4,
  parameter int RESET_LEVEL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic step_en,
  input  logic s,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } st_t;

  localparam st_t             RST_ST = (RESET_LEVEL != 0) ? HIGH : LOW;
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(DB_CYCLES - 1);

  st_t              state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RST_ST;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (step_en) begin
      case (state)
        LOW: if (s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = LOAD;
        end
        WAIT_HI: begin
          if (!s)              state_nxt = LOW;
          else if (cnt == '0)  state_nxt = HIGH;
          else                 cnt_nxt   = cnt - 1'b1;
        end
        HIGH: if (!s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = LOAD;
        end
        WAIT_LO: begin
          if (s)               state_nxt = HIGH;
          else if (cnt == '0)  state_nxt = LOW;
          else                 cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = RST_ST;
      endcase
    end
  end

  // outputs: ticks are the acceptance transitions, registered above so they
  // line up with the db_level change
  always_comb begin
    rise_nxt = (state == WAIT_HI) && (state_nxt == HIGH);
    fall_nxt = (state == WAIT_LO) && (state_nxt == LOW);
    level    = (state == HIGH) || (state == WAIT_LO);
    busy     = (state == WAIT_HI) || (state == WAIT_LO);
  end

endmodule

module multi_debounce #(
  parameter int CHANNELS    = 4,
  parameter int DB_CYCLES   = 10,
  parameter int CNT_W       = 4,
  parameter int RESET_LEVEL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en,
  input  logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] db_rise,
  output logic [CHANNELS-1:0] db_fall,
  output logic [CHANNELS-1:0] db_busy
);

  localparam logic RL = (RESET_LEVEL != 0);

  logic [CHANNELS-1:0] s;

`ifdef MULTI_DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1, sync2;

  // free-running synchroniser; reset to RESET_LEVEL so release makes no tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= {CHANNELS{RL}};
      sync2 <= {CHANNELS{RL}};
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = sw;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    multi_debounce_lane #(
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .step_en(step_en),
      .s      (s[i]),
      .level  (db_level[i]),
      .rise   (db_rise[i]),
      .fall   (db_fall[i]),
      .busy   (db_busy[i])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce -- randomized bench for multi_debounce.
// The reference model tracks each channel's accepted level and the length of
// the current run of enabled samples that disagree with it. A level is
// accepted when that run reaches DB_CYCLES+1.

module tb_multi_debounce;

  localparam int CH  = 4;
  localparam int DB  = 10;
  localparam int CW  = 4;
  localparam int RL  = 0;
`ifdef MULTI_DEBOUNCE_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step_en = 1'b1;
  logic [CH-1:0] sw = '1;
  logic [CH-1:0] db_level, db_rise, db_fall, db_busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_lvl  [CH];
  int m_run  [CH];
  bit m_rise [CH];
  bit m_fall [CH];
  bit m_pipe [CH][2];

  always #5 clk = ~clk;

  multi_debounce #(
    .CHANNELS(CH), .DB_CYCLES(DB), .CNT_W(CW), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .rst(rst), .step_en(step_en), .sw(sw),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall), .db_busy(db_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_lvl[i]  = (RL != 0);
      m_run[i]  = 0;
      m_rise[i] = 0;
      m_fall[i] = 0;
      m_pipe[i][0] = (RL != 0);
      m_pipe[i][1] = (RL != 0);
    end
  endtask

  // called right after a rising edge with the inputs that were applied at it
  task automatic model_step();
    bit s;
    if (!rst) return;
    for (int i = 0; i < CH; i++) begin
      s = (SLAT != 0) ? m_pipe[i][1] : sw[i];
      m_pipe[i][1] = m_pipe[i][0];
      m_pipe[i][0] = sw[i];
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (step_en) begin
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_lvl[i]  = s;
            m_rise[i] = s;
            m_fall[i] = !s;
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] el, er, ef, eb;
    for (int i = 0; i < CH; i++) begin
      el[i] = m_lvl[i];
      er[i] = m_rise[i];
      ef[i] = m_fall[i];
      eb[i] = (m_run[i] > 0);
    end
    chk("level", 32'(db_level), 32'(el));
    chk("rise",  32'(db_rise),  32'(er));
    chk("fall",  32'(db_fall),  32'(ef));
    chk("busy",  32'(db_busy),  32'(eb));
    chk("rise_fall_excl", 32'(db_rise & db_fall), 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  initial begin
    int n;
    int width;
    model_reset();

    // 1: reset hold with sw high, release with sw low
    #2;
    check_all();
    cycn(3);
    sw = '0;
    rst = 1'b1;
    cycn(5);

    // 2: clean press on ch0, measure latency to the rise tick
    sw[0] = 1'b1;
    n = 0;
    while (n < 40) begin
      cyc();
      n++;
      if (db_rise[0]) break;
    end
    chk("rise_latency", 32'(n), 32'(DB + 1 + SLAT));
    cycn(3);

    // 3: bounce on ch1 shorter than the debounce window
    sw[1] = 1'b1;
    cycn(5);
    sw[1] = 1'b0;
    cycn(DB + 6);

    // 4: release ch0, then simultaneous press of ch2/ch3
    sw[0] = 1'b0;
    cycn(DB + 4 + SLAT);
    sw[2] = 1'b1;
    sw[3] = 1'b1;
    cycn(DB + 4 + SLAT);

    // 5: step_en every 4th clk, press ch0, tick must stay one clk wide
    sw[0] = 1'b1;
    width = 0;
    for (int k = 0; k < 4 * (DB + 4) + SLAT; k++) begin
      step_en = (k % 4 == 3);
      cyc();
      if (db_rise[0]) width++;
    end
    chk("gated_rise_width", 32'(width), 32'd1);
    step_en = 1'b1;

    // 6: reset mid-WAIT on ch1
    sw[1] = 1'b1;
    cycn(5 + SLAT);
    async_reset();
    cycn(2);
    sw = '0;
    rst = 1'b1;
    cycn(4);

    // random phase: slow-toggling switches with bursts of bounce
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 15) == 0 || ((k / 64) % 3 == 1 && $urandom_range(0, 2) == 0))
          sw[i] = ~sw[i];
      end
      step_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        cycn(2);
        rst = 1'b1;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
